// File: rtl/uart_pkg.sv
// Shared types and frame constants for the uart_comm transceiver.
// Optional even parity is selected with the UART_PARITY_EN macro.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      DONE
   } uart_state_e;

   localparam int DATA_BITS = 8;

`ifdef UART_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   // Bits between start and stop: the data byte, plus parity when enabled.
   localparam int PAYLOAD_BITS = FRAME_BITS - 2;

   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM, byte output register.
// UART_PARITY_EN adds an even-parity check on the received frame.
//
// state | meaning
// IDLE  | line idle; waits for low (or for high again after a bad frame)
// START | half-bit wait, then re-check start bit to reject glitches
// DATA  | sample each payload bit at its centre, LSB first
// STOP  | sample stop bit; good frame -> DONE, bad frame -> IDLE guard
// DONE  | one-cycle rx_done_flag pulse
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       rx_in,
   output logic [7:0] rx_data_out,
   output logic       rx_done_flag
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [3:0]    BITS_LAST = 4'(PAYLOAD_BITS - 1);

   uart_state_e             state, state_nxt;
   logic                    rx_meta, rx_sync;
   logic [TW-1:0]           tmr;
   logic [3:0]              bits;
   logic [PAYLOAD_BITS-1:0] shreg;
   logic                    guard;
   logic                    tmr_tc;
   logic                    frame_ok;

   assign tmr_tc = (tmr == '0);

`ifdef UART_PARITY_EN
   assign frame_ok = rx_sync && !(^shreg);
`else
   assign frame_ok = rx_sync;
`endif

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state       <= IDLE;
         rx_meta     <= 1'b1;
         rx_sync     <= 1'b1;
         tmr         <= TW'(1);
         bits        <= 4'd1;
         shreg       <= '0;
         guard       <= 1'b0;
         rx_data_out <= '0;
      end else begin
         state   <= state_nxt;
         rx_meta <= rx_in;
         rx_sync <= rx_meta;

         // IDLE preloads a half bit so START lands on the start-bit centre.
         if (state == IDLE)
            tmr <= HALF_LAST;
         else if (tmr_tc)
            tmr <= BIT_LAST;
         else
            tmr <= tmr - 1'b1;

         if (state == START)
            bits <= BITS_LAST;
         else if (state == DATA && tmr_tc)
            bits <= bits - 4'd1;

         if (state == DATA && tmr_tc)
            shreg <= {rx_sync, shreg[PAYLOAD_BITS-1:1]};

         if (state == STOP && tmr_tc) begin
            if (frame_ok)
               rx_data_out <= shreg[DATA_BITS-1:0];
            else
               guard <= 1'b1;
         end else if (state == IDLE && rx_sync) begin
            guard <= 1'b0;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      rx_done_flag = 1'b0;
      case (state)
         IDLE:  if (!guard && !rx_sync) state_nxt = START;
         START: if (tmr_tc) state_nxt = rx_sync ? IDLE : DATA;
         DATA:  if (tmr_tc && bits == 4'd0) state_nxt = STOP;
         STOP:  if (tmr_tc) state_nxt = frame_ok ? DONE : IDLE;
         DONE: begin
            rx_done_flag = 1'b1;
            state_nxt    = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: rtl/uart_comm.sv
// Full-duplex UART transceiver top: inline TX FSM plus the uart_rx receiver.
// UART_PARITY_EN inserts an even-parity bit after data bit 7.
//
// state | meaning
// IDLE  | tx_out high; latch byte and start on tx_start
// START | start bit (low) for one bit time
// DATA  | payload bits LSB first, one bit time each
// STOP  | stop bit (high) for one bit time
// DONE  | one-cycle tx_done_flag pulse, line high
module uart_comm
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       tx_start,
   input  logic [7:0] tx_data_in,
   output logic       tx_out,
   input  logic       rx_in,
   output logic [7:0] rx_data_out,
   output logic       rx_done_flag,
   output logic       tx_done_flag
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    BITS_LAST = 4'(PAYLOAD_BITS - 1);

   uart_state_e             tx_state, tx_state_nxt;
   logic [TW-1:0]           tx_tmr;
   logic [3:0]              tx_bits;
   logic [PAYLOAD_BITS-1:0] tx_shreg;
   logic [PAYLOAD_BITS-1:0] tx_load;
   logic                    tx_tc;

   assign tx_tc = (tx_tmr == '0);

`ifdef UART_PARITY_EN
   assign tx_load = {even_parity(tx_data_in), tx_data_in};
`else
   assign tx_load = tx_data_in;
`endif

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         tx_state <= IDLE;
         tx_tmr   <= TW'(1);
         tx_bits  <= 4'd1;
         tx_shreg <= '0;
      end else begin
         tx_state <= tx_state_nxt;

         if (tx_state == IDLE || tx_tc)
            tx_tmr <= BIT_LAST;
         else
            tx_tmr <= tx_tmr - 1'b1;

         if (tx_state == START)
            tx_bits <= BITS_LAST;
         else if (tx_state == DATA && tx_tc)
            tx_bits <= tx_bits - 4'd1;

         if (tx_state == IDLE && tx_start)
            tx_shreg <= tx_load;
         else if (tx_state == DATA && tx_tc)
            tx_shreg <= tx_shreg >> 1;
      end
   end

   always_comb begin
      tx_state_nxt = tx_state;
      tx_out       = 1'b1;
      tx_done_flag = 1'b0;
      case (tx_state)
         IDLE:  if (tx_start) tx_state_nxt = START;
         START: begin
            tx_out = 1'b0;
            if (tx_tc) tx_state_nxt = DATA;
         end
         DATA: begin
            tx_out = tx_shreg[0];
            if (tx_tc && tx_bits == 4'd0) tx_state_nxt = STOP;
         end
         STOP:  if (tx_tc) tx_state_nxt = DONE;
         DONE: begin
            tx_done_flag = 1'b1;
            tx_state_nxt = IDLE;
         end
         default: tx_state_nxt = IDLE;
      endcase
   end

   uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .rx_in       (rx_in),
      .rx_data_out (rx_data_out),
      .rx_done_flag(rx_done_flag)
   );

endmodule

// File: tb/tb_uart_comm.sv
// Directed self-checking bench for uart_comm at 16 clocks per bit.
// Follows UART_PARITY_EN for frame length and parity bit.
module tb_uart_comm;

   localparam int CPB = 16;
`ifdef UART_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx_start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_out;
   logic       rx_in;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       tx_done;
   logic       rx_drv = 1'b1;
   logic       loop_en = 1'b0;

   int         vec_cnt = 0;
   int         err_cnt = 0;
   int         rx_cnt = 0;
   logic [7:0] rx_q[$];

   assign rx_in = loop_en ? tx_out : rx_drv;

   always #5 clk = ~clk;

   uart_comm #(.CLKS_PER_BIT(CPB)) dut (
      .clk_in      (clk),
      .rst_n_in    (rst_n),
      .tx_start    (tx_start),
      .tx_data_in  (tx_data),
      .tx_out      (tx_out),
      .rx_in       (rx_in),
      .rx_data_out (rx_data),
      .rx_done_flag(rx_done),
      .tx_done_flag(tx_done)
   );

   always @(negedge clk) begin
      if (rx_done === 1'b1) begin
         rx_cnt++;
         rx_q.push_back(rx_data);
      end
   end

   function automatic logic [FB-1:0] frame_bits(input logic [7:0] d, input logic stop);
`ifdef UART_PARITY_EN
      return {stop, ^d, d, 1'b0};
`else
      return {stop, d, 1'b0};
`endif
   endfunction

   task automatic wait_tx_low(input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (tx_out === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         vec_cnt++; err_cnt++;
         $display("FAIL %s: start bit never seen within 400 cycles", name);
      end
   endtask

   // Counts negedges from the current one until tx_done_flag is seen.
   task automatic wait_tx_done(input string name, output int n);
      n = -1;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         if (tx_done === 1'b1) begin
            n = i;
            break;
         end
      end
      if (n < 0) begin
         vec_cnt++; err_cnt++;
         $display("FAIL %s: tx_done_flag never seen within 400 cycles", name);
      end
   endtask

   task automatic drive_frame(input logic [7:0] d, input logic stop);
      logic [FB-1:0] f;
      f = frame_bits(d, stop);
      for (int i = 0; i < FB; i++) begin
         rx_drv = f[i];
         repeat (CPB) @(negedge clk);
      end
      rx_drv = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vec_cnt++; if (tx_out !== 1'b1) begin err_cnt++; $display("FAIL reset_tx_out: got %b expected 1", tx_out); end
      vec_cnt++; if (rx_data !== 8'h00) begin err_cnt++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
      vec_cnt++; if (rx_done !== 1'b0) begin err_cnt++; $display("FAIL reset_rx_done: got %b expected 0", rx_done); end
      vec_cnt++; if (tx_done !== 1'b0) begin err_cnt++; $display("FAIL reset_tx_done: got %b expected 0", tx_done); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_glitch();
      int c0;
      c0 = rx_cnt;
      rx_drv = 1'b0;
      repeat (3) @(negedge clk);
      rx_drv = 1'b1;
      repeat (40) @(negedge clk);
      vec_cnt++; if (rx_cnt !== c0) begin err_cnt++; $display("FAIL glitch_pulse: got %0d pulses expected %0d", rx_cnt, c0); end
      vec_cnt++; if (rx_data !== 8'h00) begin err_cnt++; $display("FAIL glitch_data: got %h expected 00", rx_data); end
   endtask

   task automatic test_framing();
      int c0;
      c0 = rx_cnt;
      drive_frame(8'h3C, 1'b0);
      repeat (40) @(negedge clk);
      vec_cnt++; if (rx_cnt !== c0) begin err_cnt++; $display("FAIL framing_pulse: got %0d pulses expected %0d", rx_cnt, c0); end
      vec_cnt++; if (rx_data !== 8'h00) begin err_cnt++; $display("FAIL framing_data: got %h expected 00", rx_data); end
      drive_frame(8'h5A, 1'b1);
      repeat (20) @(negedge clk);
      vec_cnt++; if (rx_cnt !== c0 + 1) begin err_cnt++; $display("FAIL framing_recover_pulse: got %0d pulses expected %0d", rx_cnt, c0 + 1); end
      vec_cnt++; if (rx_data !== 8'h5A) begin err_cnt++; $display("FAIL framing_recover_data: got %h expected 5a", rx_data); end
   endtask

   task automatic test_loopback_a5();
      bit ok;
      int n, rx_n, m;
      logic [7:0] rx_v;
      loop_en  = 1'b1;
      tx_data  = 8'hA5;
      tx_start = 1'b1;
      wait_tx_low("a5_start", ok);
      if (ok) begin
         n = 0; rx_n = -1; rx_v = 8'h00;
         while (n < 400) begin
            @(negedge clk);
            n++;
            if (rx_done === 1'b1 && rx_n < 0) begin rx_n = n; rx_v = rx_data; end
            if (tx_done === 1'b1) break;
         end
         vec_cnt++; if (n !== CPB * FB) begin err_cnt++; $display("FAIL a5_tx_done_cycle: got %0d expected %0d", n, CPB * FB); end
         vec_cnt++; if (rx_n !== CPB * FB - 5) begin err_cnt++; $display("FAIL a5_rx_done_cycle: got %0d expected %0d", rx_n, CPB * FB - 5); end
         vec_cnt++; if (rx_v !== 8'hA5) begin err_cnt++; $display("FAIL a5_rx_data: got %h expected a5", rx_v); end
         m = 0;
         while (m < 10) begin
            @(negedge clk);
            m++;
            if (tx_out === 1'b0) break;
         end
         vec_cnt++; if (m !== 2) begin err_cnt++; $display("FAIL a5_gap: got %0d cycles expected 2", m); end
         // Second frame latched A5; changing the input mid-frame must not matter.
         tx_start = 1'b0;
         repeat (40) @(negedge clk);
         tx_data = 8'hFF;
         wait_tx_done("a5_second", n);
         vec_cnt++; if (rx_data !== 8'hA5) begin err_cnt++; $display("FAIL a5_midframe_change: got %h expected a5", rx_data); end
      end
      tx_start = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_random();
      logic [7:0] b[10];
      int n;
      rx_q.delete();
      for (int i = 0; i < 10; i++) b[i] = 8'($urandom_range(200, 10));
      tx_data  = b[0];
      tx_start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wait_tx_done("random_frame", n);
         if (i < 9) tx_data = b[i+1];
         else tx_start = 1'b0;
      end
      repeat (5) @(negedge clk);
      vec_cnt++; if (rx_q.size() !== 10) begin err_cnt++; $display("FAIL random_count: got %0d expected 10", rx_q.size()); end
      for (int i = 0; i < 10; i++) begin
         vec_cnt++;
         if (i >= rx_q.size()) begin
            err_cnt++; $display("FAIL random_byte%0d: got none expected %h", i, b[i]);
         end else if (rx_q[i] !== b[i]) begin
            err_cnt++; $display("FAIL random_byte%0d: got %h expected %h", i, rx_q[i], b[i]);
         end
      end
   endtask

   task automatic test_bit_timing();
      bit ok, bad;
      int n;
      logic [FB-1:0] f;
      f = frame_bits(8'h01, 1'b1);
      tx_data  = 8'h01;
      tx_start = 1'b1;
      wait_tx_low("timing_start", ok);
      tx_start = 1'b0;
      if (ok) begin
         for (int b = 0; b < FB; b++) begin
            bad = 1'b0;
            for (int c = 0; c < CPB; c++) begin
               if (b > 0 || c > 0) @(negedge clk);
               if (tx_out !== f[b]) bad = 1'b1;
            end
            vec_cnt++;
            if (bad) begin err_cnt++; $display("FAIL timing_bit%0d: got %b at some cycle expected %b for %0d cycles", b, tx_out, f[b], CPB); end
         end
         wait_tx_done("timing_done", n);
         vec_cnt++; if (n !== 1) begin err_cnt++; $display("FAIL timing_done_cycle: got %0d expected 1 after last bit", n); end
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_midframe();
      bit ok;
      int n, c0;
      tx_data  = 8'h33;
      tx_start = 1'b1;
      wait_tx_low("midreset_start", ok);
      tx_start = 1'b0;
      repeat (CPB + 4 * CPB + CPB / 2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      vec_cnt++; if (tx_out !== 1'b1) begin err_cnt++; $display("FAIL midreset_tx_out: got %b expected 1", tx_out); end
      vec_cnt++; if (tx_done !== 1'b0) begin err_cnt++; $display("FAIL midreset_tx_done: got %b expected 0", tx_done); end
      vec_cnt++; if (rx_done !== 1'b0) begin err_cnt++; $display("FAIL midreset_rx_done: got %b expected 0", rx_done); end
      vec_cnt++; if (rx_data !== 8'h00) begin err_cnt++; $display("FAIL midreset_rx_data: got %h expected 00", rx_data); end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      c0 = rx_cnt;
      tx_data  = 8'hC3;
      tx_start = 1'b1;
      wait_tx_low("midreset_new_start", ok);
      tx_start = 1'b0;
      if (ok) begin
         wait_tx_done("midreset_new_done", n);
         vec_cnt++; if (n !== CPB * FB) begin err_cnt++; $display("FAIL midreset_frame_len: got %0d expected %0d", n, CPB * FB); end
         vec_cnt++; if (rx_cnt !== c0 + 1) begin err_cnt++; $display("FAIL midreset_rx_pulse: got %0d expected %0d", rx_cnt, c0 + 1); end
         vec_cnt++; if (rx_data !== 8'hC3) begin err_cnt++; $display("FAIL midreset_rx_data: got %h expected c3", rx_data); end
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_framing();
      test_loopback_a5();
      test_random();
      test_bit_timing();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_comm.md
Name: uart_comm

Overview:
Full-duplex 8N1 UART transceiver: an independent transmitter and receiver sharing one clock. The transmitter serialises a byte on tx_out; the receiver deserialises rx_in into rx_data_out. The block sits between a byte-oriented host and a serial pin pair, and supports external loopback with tx_out wired to rx_in.

Parameters:
CLKS_PER_BIT, 868, clk_in cycles per serial bit (100 MHz / 115200 baud); legal range ≥ 4.

Ports:
clk_in  input  1  system clock; all logic on rising edge
rst_n_in  input  1  synchronous, active-low reset
tx_start  input  1  request a transmit; level-sensitive
tx_data_in  input  8  byte to send; sampled when a frame starts
tx_out  output  1  serial transmit line; idles high
rx_in  input  1  serial receive line; asynchronous
rx_data_out  output  8  last correctly framed received byte
rx_done_flag  output  1  one-cycle pulse when a byte is received
tx_done_flag  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (rst_n_in=0 at a clock edge): tx_out=1, rx_data_out=0, rx_done_flag=0, tx_done_flag=0; both FSMs go to IDLE; counters and the synchroniser are set to 1.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. Every bit lasts exactly CLKS_PER_BIT cycles.
- TX FSM states: IDLE, START, DATA, STOP, DONE.
  - IDLE: tx_out=1. If tx_start=1, latch tx_data_in and go to START.
  - START, DATA (8 bits), STOP: each bit lasts CLKS_PER_BIT cycles.
  - DONE: one cycle with tx_done_flag=1 and tx_out=1, then IDLE.
  - tx_start held high sends back-to-back frames with a 2-cycle high gap (DONE plus IDLE).
  - tx_data_in changes mid-frame are ignored.
  - tx_start is ignored outside IDLE.
- RX path: rx_in passes through a 2-flop synchroniser.
- RX FSM states: IDLE, START, DATA, STOP, DONE.
  - IDLE: a low synchronised input goes to START.
  - START: re-sample at cycle CLKS_PER_BIT/2 (integer division). If still low, go to DATA; otherwise it is a glitch, return to IDLE.
  - DATA: sample each data bit at its centre, i.e. every CLKS_PER_BIT cycles, shifting in LSB first.
  - STOP: sample the stop bit at its centre. If 1, update rx_data_out, pulse rx_done_flag for one cycle (DONE), then IDLE. If 0 (framing error), rx_data_out is unchanged, there is no pulse, and the FSM waits in IDLE-guard until rx_in is high.
- rx_data_out holds its value until the next good frame.
- In loopback, rx_done_flag fires about CLKS_PER_BIT/2 cycles before tx_done_flag for the same frame.
- TX and RX are fully independent; simultaneous activity is allowed.
- Reset mid-frame aborts immediately; tx_out returns high on the next cycle.

Optional Feature:
UART_PARITY_EN:
- Defined: an even-parity bit is inserted after data bit 7 (frame is 11 bits). TX computes parity over the latched byte. RX checks it; on a mismatch the byte is discarded (no rx_done_flag pulse, rx_data_out unchanged), handled the same as a framing error.
- Undefined: plain 8N1 with no parity logic.

Decomposition:
- Package uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP, DONE}, shared by TX and RX;
  - DATA_BITS=8;
  - the frame-length constant (10, or 11 with parity).
- Natural sub-module: uart_rx (synchroniser, RX FSM, rx_data_out and rx_done_flag). The TX FSM stays inline in uart_comm.

Test Plan:
- CLKS_PER_BIT=16, loopback, tx_start held 1, tx_data_in=0xA5:
  - rx_done_flag pulses with rx_data_out=0xA5 (8 cycles plus synchroniser delay before the end of stop);
  - tx_done_flag pulses exactly 160 cycles after the start bit began.
- Loopback, 10 random bytes in 10..200, changing tx_data_in after each tx_done_flag: every rx_data_out matches its byte and the order is preserved.
- Bit timing: send 0x01 and check tx_out. It is low for 16 cycles, high 16 (bit0), low 112 (bits 1-7), then high for the stop bit.
- Glitch: drive rx_in low for 3 cycles while RX idle -> no rx_done_flag and rx_data_out stays 0x00.
- Framing error: drive a frame for 0x3C with stop bit 0 -> no rx_done_flag and rx_data_out unchanged. A following good frame 0x5A is received correctly.
- Reset mid-frame at bit 4: tx_out=1 and all outputs are at reset values on the next cycle. A new tx_start then sends a complete frame.
